// File: rtl/wb_arb_pkg_hdl.sv
// Shared definitions for the Wishbone arbiter: FSM state type, width defaults
// and a small index helper used by the RTL and HDL-side bus models.
package wb_arb_pkg_hdl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } wb_arb_state_t;

  localparam int DEF_NUM_MASTERS    = 4;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module wb_rr_picker
  import wb_arb_pkg_hdl::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int PW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [PW-1:0]          idx,
  output logic                   valid
);

  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter, NUM_MASTERS masters onto one slave.
// Optional bus watchdog with abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg_hdl::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc,
  input  logic [NUM_MASTERS-1:0]              m_stb,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_o,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [DATA_WIDTH-1:0]               m_dat_i,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADDR_WIDTH-1:0]               s_adr,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel,
  input  logic                                s_ack,
  input  logic                                s_err,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]              grant,
  output logic                                busy
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_WIDTH / 8;

  wb_arb_state_t           state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [PW-1:0]           owner_q;
  logic [PW-1:0]           ptr_q;
  logic [NUM_MASTERS-1:0]  pick_gnt;
  logic [PW-1:0]           pick_idx;
  logic                    pick_valid;
  logic                    own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]   own_adr;
  logic [DATA_WIDTH-1:0]   own_dat;
  logic [SW-1:0]           own_sel;
  logic                    timeout_hit;

  wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .PW(PW)) u_picker (
    .req   (m_cyc),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == i[PW-1:0]) begin
        own_cyc = m_cyc[i];
        own_stb = m_stb[i];
        own_we  = m_we[i];
        own_adr = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_dat = m_dat_o[i*DATA_WIDTH +: DATA_WIDTH];
        own_sel = m_sel[i*SW +: SW];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_q;

  assign timeout_hit = (state_q == BUSY) && own_stb && !s_ack && !s_err && (wd_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || state_q != BUSY || state_d != BUSY || s_ack || s_err) begin
      wd_q <= '0;
    end else if (own_stb) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  // No watchdog: the limit parameter only keeps the interface uniform.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY: begin
        if (!own_cyc)         state_d = IDLE;
        else if (timeout_hit) state_d = ABORT;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != IDLE && state_d == IDLE) begin
        grant_q <= '0;
        ptr_q   <= PW'(wrap_inc(int'(owner_q), NUM_MASTERS));
      end else if (state_q == IDLE && pick_valid) begin
        grant_q <= pick_gnt;
        owner_q <= pick_idx;
      end
    end
  end

  // ABORT keeps grant so the error pulse reaches the master that stalled.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    m_ack   = '0;
    m_err   = '0;
    if (state_q == BUSY) begin
      s_cyc   = own_cyc;
      s_stb   = own_stb;
      s_we    = own_we;
      s_adr   = own_adr;
      s_dat_o = own_dat;
      s_sel   = own_sel;
      m_ack   = grant_q & {NUM_MASTERS{s_ack}};
      m_err   = grant_q & {NUM_MASTERS{s_err}};
    end else if (state_q == ABORT) begin
      m_err   = grant_q;
    end
  end

  assign m_dat_i = s_dat_i;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-cycle reference model of ownership.
// Watchdog scenario compiled in when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat_o;
  logic [N*SW-1:0]   m_sel;
  logic [DW-1:0]     m_dat_i, s_dat_o, s_dat_i;
  logic              s_cyc, s_stb, s_we, s_ack, s_err, busy;
  logic [AW-1:0]     s_adr;
  logic [SW-1:0]     s_sel;

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_dat_i(m_dat_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err), .s_dat_i(s_dat_i),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  logic [N-1:0] glog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the slave, whether an abort pulse is pending,
  // where the next search starts, and how many stalled strobes have elapsed.
  int mo_owner = -1;
  bit mo_abort = 1'b0;
  int mo_ptr   = 0;
  int mo_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      mo_owner = -1; mo_abort = 1'b0; mo_ptr = 0; mo_cnt = 0;
    end else if (mo_abort) begin
      mo_ptr = (mo_owner + 1) % N; mo_owner = -1; mo_abort = 1'b0; mo_cnt = 0;
    end else if (mo_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (mo_owner < 0 && m_cyc[(mo_ptr + k) % N]) mo_owner = (mo_ptr + k) % N;
    end else begin
      if (!m_cyc[mo_owner]) begin
        mo_ptr = (mo_owner + 1) % N; mo_owner = -1; mo_cnt = 0;
      end
`ifdef WB_ARB_TIMEOUT_EN
      else if (s_ack || s_err) mo_cnt = 0;
      else if (m_stb[mo_owner]) begin
        if (mo_cnt == TO - 1) begin mo_abort = 1'b1; mo_cnt = 0; end
        else mo_cnt++;
      end
`endif
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, eack, eerr;
    logic ecyc, estb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW-1:0] esel;
    if (chk_en) begin
      eg = '0; eack = '0; eerr = '0; ecyc = 0; estb = 0; ewe = 0; eadr = '0; edat = '0; esel = '0;
      if (mo_owner >= 0) eg[mo_owner] = 1'b1;
      if (mo_owner >= 0 && !mo_abort) begin
        ecyc = m_cyc[mo_owner]; estb = m_stb[mo_owner]; ewe = m_we[mo_owner];
        eadr = m_adr[mo_owner*AW +: AW]; edat = m_dat_o[mo_owner*DW +: DW]; esel = m_sel[mo_owner*SW +: SW];
        if (s_ack) eack = eg;
        if (s_err) eerr = eg;
      end else if (mo_abort) begin
        eerr = eg;
      end
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(mo_owner >= 0));
      chk("s_cyc", 64'(s_cyc), 64'(ecyc));
      chk("s_stb", 64'(s_stb), 64'(estb));
      chk("s_we", 64'(s_we), 64'(ewe));
      chk("s_adr", 64'(s_adr), 64'(eadr));
      chk("s_dat_o", 64'(s_dat_o), 64'(edat));
      chk("s_sel", 64'(s_sel), 64'(esel));
      chk("m_ack", 64'(m_ack), 64'(eack));
      chk("m_err", 64'(m_err), 64'(eerr));
      chk("m_dat_i", 64'(m_dat_i), 64'(s_dat_i));
      if (log_en) glog.push_back(grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_o = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [N-1:0] pending, acked, prev;
    bit done, round2;
    int order[$];
    int direct;

    clear_inputs();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    // Single read by master 2, slave answers in the third granted cycle.
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100; m_adr[2*AW +: AW] = 32'h0000_2040; m_sel[2*SW +: SW] = 2'b11;
    sample();
    chk("s1_grant_pre", 64'(grant), 64'h0);
    tick();
    sample();
    chk("s1_grant", 64'(grant), 64'h4);
    chk("s1_s_adr", 64'(s_adr), 64'h2040);
    tick();
    tick();
    s_ack = 1'b1; s_dat_i = 16'hBEEF;
    sample();
    chk("s1_ack", 64'(m_ack), 64'h4);
    chk("s1_rdata", 64'(m_dat_i), 64'hBEEF);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
    sample();
    chk("s1_idle", 64'(grant), 64'h0);

    // All four request; each releases after one acked transfer, then master 0 again.
    do_reset();
    pending = 4'hF; acked = '0; done = 0; round2 = 0;
    glog.delete();
    log_en = 1'b1;
    for (int c = 0; c < 80 && !done; c++) begin
      m_cyc = pending; m_stb = pending;
      s_ack = (grant != 0) && ((pending & grant) != 0) && ((acked & grant) == 0);
      sample();
      acked |= m_ack;
      tick();
      pending &= ~acked;
      if (pending == 0 && !round2) begin
        pending = 4'b0001; acked = '0; round2 = 1;
      end else if (pending == 0 && round2) begin
        done = 1;
      end
    end
    log_en = 1'b0;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    chk("s2_done", 64'(done), 64'h1);
    prev = '0; direct = 0;
    foreach (glog[i]) begin
      if (glog[i] != 0 && glog[i] != prev)
        for (int b = 0; b < N; b++) if (glog[i][b]) order.push_back(b);
      if (prev != 0 && glog[i] != 0 && glog[i] != prev) direct++;
      prev = glog[i];
    end
    chk("s2_order_len", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("s2_order", 64'(i < order.size() ? order[i] : -1), 64'(exp_order[i]));
    chk("s2_no_gap", 64'(direct), 64'd0);

    // Master 1 holds the bus for five writes while master 0 waits.
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010; m_we = 4'b0010; m_sel[1*SW +: SW] = 2'b01;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      m_adr[1*AW +: AW] = 32'h1000 + k; m_dat_o[1*DW +: DW] = 16'(k + 16'h0A00);
      s_ack = 1'b1;
      sample();
      chk("s3_hold", 64'(grant), 64'h2);
      chk("s3_ack", 64'(m_ack), 64'h2);
      tick();
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    sample();
    chk("s3_last", 64'(grant), 64'h2);
    tick();
    sample();
    chk("s3_gap", 64'(grant), 64'h0);
    tick();
    sample();
    chk("s3_next", 64'(grant), 64'h1);

    // Reset while master 2 owns the bus, then 0 and 3 request together.
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    tick();
    sample();
    chk("s4_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; m_cyc = 4'b1001; m_stb = 4'b1001;
    sample();
    chk("s4_grant0", 64'(grant), 64'h0);
    chk("s4_busy0", 64'(busy), 64'h0);
    chk("s4_scyc0", 64'(s_cyc), 64'h0);
    tick();
    sample();
    chk("s4_winner", 64'(grant), 64'h1);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers master 1: abort after TO stalled strobes.
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    sample();
    chk("s5_grant", 64'(grant), 64'h2);
    for (int k = 2; k <= TO; k++) begin
      tick();
      sample();
      chk("s5_wait", 64'(m_err), 64'h0);
    end
    tick();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    sample();
    chk("s5_err", 64'(m_err), 64'h2);
    chk("s5_scyc", 64'(s_cyc), 64'h0);
    tick();
    sample();
    chk("s5_err_end", 64'(m_err), 64'h0);
    chk("s5_idle", 64'(busy), 64'h0);
    tick();
    sample();
    chk("s5_ptr", 64'(grant), 64'h4);
`endif

    do_reset();
    sample();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 Parameter DATA_WIDTH, default 16, Wishbone data width; SEL width = DATA_WIDTH/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, watchdog limit in cycles (only meaningful with WB_ARB_TIMEOUT_EN).
REQ-005 Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous active-high reset
m_cyc  in  NUM_MASTERS  per-master bus request/cycle
m_stb  in  NUM_MASTERS  per-master strobe
m_we  in  NUM_MASTERS  per-master write enable
m_adr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, packed
m_dat_o  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed
m_sel  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte selects, packed
m_ack  out  NUM_MASTERS  ack routed to owner only
m_err  out  NUM_MASTERS  err routed to owner only
m_dat_i  out  DATA_WIDTH  slave read data, broadcast
s_cyc, s_stb, s_we  out  1 each  slave-side cycle/strobe/write
s_adr  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel  out  DATA_WIDTH/8  slave byte selects
s_ack, s_err  in  1 each  slave termination
s_dat_i  in  DATA_WIDTH  slave read data
grant  out  NUM_MASTERS  one-hot registered owner, 0 when idle
busy  out  1  high in BUSY/ABORT

Function
REQ-006 FSM states IDLE, BUSY, ABORT; IDLE->BUSY when any m_cyc high; BUSY->IDLE when m_cyc[owner] low; ABORT->IDLE unconditionally after one cycle.
REQ-007 Arbitration in IDLE: round-robin, search starts at pointer; winner registered into grant; slave sees owner's request the cycle after IDLE (1-cycle arbitration latency).
REQ-008 Pointer SHALL update to (owner+1) mod NUM_MASTERS on every BUSY->IDLE or ABORT->IDLE; unchanged otherwise.
REQ-009 In BUSY: s_cyc/s_stb/s_we/s_adr/s_dat_o/s_sel combinationally muxed from owner; non-owner requests ignored.
REQ-010 m_ack[owner]=s_ack, m_err[owner]=s_err combinationally in BUSY; all other bits 0; m_dat_i=s_dat_i always.
REQ-011 In IDLE and ABORT: s_cyc=s_stb=s_we=0, s_adr/s_dat_o/s_sel=0.
REQ-012 Owner may run any number of back-to-back or pipelined strobes while m_cyc[owner] stays high; no preemption.
REQ-013 Simultaneous requests with pointer=k: lowest index at or above k (wrapping) wins.
REQ-014 Owner dropping m_cyc with s_ack same cycle: ack delivered, state IDLE next cycle, one idle cycle minimum between owners.
REQ-015 s_ack and s_err both high: both forwarded unchanged; arbiter takes no action.

Reset
REQ-016 rst at clock edge, including mid-transaction: state IDLE, pointer 0, grant 0, busy 0, watchdog count 0; combinational outputs follow REQ-011 and m_ack/m_err=0 from next cycle.

Configuration
REQ-017 Macro WB_ARB_TIMEOUT_EN defined: counter increments each BUSY cycle with s_stb high and s_ack/s_err low; clears on ack/err or leaving BUSY; when count reaches TIMEOUT_CYCLES-1 with no termination, next state ABORT; ABORT drives m_err[owner]=1 for exactly one cycle with s_cyc low.
REQ-018 s_ack in the cycle count reaches limit: ack wins, no abort.
REQ-019 Macro undefined: no counter, no ABORT entry; BUSY held indefinitely.

Structure
REQ-020 Shared package wb_arb_pkg_hdl holds state typedef wb_arb_state_t (IDLE/BUSY/ABORT) and width defaults; imported by RTL and HDL-side BFMs.
REQ-021 Sub-module wb_rr_picker: combinational round-robin picker (request vector, pointer -> one-hot grant, valid).

Verification
REQ-022 Only master 2 requests, single read, slave acks after 3 cycles -> grant=4'b0100 one cycle after m_cyc, m_ack[2] with slave ack, m_dat_i=s_dat_i (e.g. 16'hBEEF).
REQ-023 All four request continuously, each one transfer -> grant order 0,1,2,3,0 with one idle cycle between owners.
REQ-024 Master 1 holds m_cyc for 5 writes while master 0 requests -> no switch until master 1 drops m_cyc; master 0 granted next.
REQ-025 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> ABORT after 16 strobe cycles, m_err[owner] 1-cycle pulse, s_cyc low, pointer advanced.
REQ-026 rst asserted mid-BUSY -> next cycle grant=0, busy=0, s_cyc=0; after release master 0 wins simultaneous requests from 0 and 3.
